// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle rx_ready / framing_err pulses.
// Latency ~HALF + 9*CLKS_PER_BIT + 4 cycles from line edge to rx_ready; no backpressure, pulses are not held.
module uart_rx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       framing_err,
    output logic       rx_busy
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        CLEAN = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       byte_nxt;
    logic             ready_nxt, ferr_nxt;
    logic             sync1, rx_s, rx_prev;
    logic             fall;

    // Synchronizer and previous-sample flops idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_serial;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign fall = !rx_s && rx_prev;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
            rx_byte     <= 8'h00;
            rx_ready    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift_reg   <= shift_nxt;
            rx_byte     <= byte_nxt;
            rx_ready    <= ready_nxt;
            framing_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        byte_nxt    = rx_byte;
        ready_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (fall) state_nxt = START;
            end
            START: begin
                // Re-check the line mid-start-bit; a high here means the edge was a glitch
                if (cnt == HALF) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt   = STOP;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = CLEAN;
                    if (rx_s) begin
                        byte_nxt  = shift_reg;
                        ready_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end
            CLEAN: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                bit_idx_nxt = 3'd0;
                shift_nxt   = 8'h00;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: framing, glitch rejection, break, mid-frame reset, loopback.
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int HALF = (CPB - 1) / 2;
    // Cycles from driving the start bit to seeing rx_ready at the following negedge
    localparam int LAT  = 4 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_ready, framing_err, rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         both_cnt = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .rx_serial   (rx_serial),
        .rx_byte     (rx_byte),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_ready) begin
            got_q.push_back(rx_byte);
            got_cyc.push_back(cyc);
        end
        if (framing_err) ferr_cnt++;
        if (rx_busy) busy_cnt++;
        if (rx_ready && framing_err) both_cnt++;
    end

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_serial = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h expected 00", rx_byte); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", rx_ready); end
        checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", framing_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", rx_busy); end
        nRst = 1'b1;
        idle(5);
    endtask

    task automatic test_single();
        int b, f, bu, t0, lat;
        b = got_q.size(); f = ferr_cnt; bu = busy_cnt;
        send_frame(8'hA5, 1'b1, t0);
        idle(10);
        checks++; if (got_q.size() != b + 1) begin errors++; $display("FAIL single_pulses got %0d expected 1", got_q.size() - b); end
        checks++;
        if (got_q.size() <= b || got_q[b] !== 8'hA5) begin
            errors++; $display("FAIL single_byte got %h expected a5", (got_q.size() > b) ? got_q[b] : 8'hxx);
        end
        lat = (got_cyc.size() > b) ? got_cyc[b] - t0 : -1;
        checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL single_latency got %0d expected %0d+-1", lat, LAT); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL single_hold got %h expected a5", rx_byte); end
        checks++; if (ferr_cnt != f) begin errors++; $display("FAIL single_ferr got %0d expected 0", ferr_cnt - f); end
        checks++;
        if (busy_cnt - bu < 76 || busy_cnt - bu > 78) begin
            errors++; $display("FAIL single_busy_cycles got %0d expected 76..78", busy_cnt - bu);
        end
    endtask

    task automatic test_glitch();
        int b, f, bu;
        b = got_q.size(); f = ferr_cnt; bu = busy_cnt;
        rx_serial = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(40);
        checks++; if (got_q.size() != b) begin errors++; $display("FAIL glitch_pulses got %0d expected 0", got_q.size() - b); end
        checks++; if (ferr_cnt != f) begin errors++; $display("FAIL glitch_ferr got %0d expected 0", ferr_cnt - f); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL glitch_byte got %h expected a5", rx_byte); end
        checks++;
        if (busy_cnt - bu < 3 || busy_cnt - bu > 5) begin
            errors++; $display("FAIL glitch_busy_cycles got %0d expected 3..5", busy_cnt - bu);
        end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b expected 0", rx_busy); end
    endtask

    task automatic test_framing();
        int b, f, t0;
        b = got_q.size(); f = ferr_cnt;
        send_frame(8'h3C, 1'b0, t0);
        rx_serial = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (ferr_cnt - f != 1) begin errors++; $display("FAIL framing_err_pulses got %0d expected 1", ferr_cnt - f); end
        checks++; if (got_q.size() != b) begin errors++; $display("FAIL framing_ready got %0d expected 0", got_q.size() - b); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL framing_byte got %h expected a5", rx_byte); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b expected 0", rx_busy); end
        idle(16);
        checks++; if (got_q.size() != b || ferr_cnt - f != 1) begin errors++; $display("FAIL break_release got %0d pulses expected 0", got_q.size() - b); end
        send_frame(8'h5A, 1'b1, t0);
        idle(4);
        checks++;
        if (got_q.size() != b + 1 || rx_byte !== 8'h5A) begin
            errors++; $display("FAIL after_break got %h (%0d pulses) expected 5a", rx_byte, got_q.size() - b);
        end
    endtask

    task automatic test_back_to_back();
        int b, f, t0, t1;
        b = got_q.size(); f = ferr_cnt;
        send_frame(8'h48, 1'b1, t0);
        send_frame(8'h49, 1'b1, t1);
        idle(10);
        checks++; if (got_q.size() != b + 2) begin errors++; $display("FAIL b2b_pulses got %0d expected 2", got_q.size() - b); end
        checks++;
        if (got_q.size() < b + 2 || got_q[b] !== 8'h48 || got_q[b+1] !== 8'h49) begin
            errors++; $display("FAIL b2b_bytes got %0d pulses expected 48 then 49", got_q.size() - b);
        end
        checks++;
        if (got_cyc.size() < b + 2 || got_cyc[b+1] - got_cyc[b] != 10 * CPB) begin
            errors++; $display("FAIL b2b_spacing got %0d expected %0d", (got_cyc.size() >= b + 2) ? got_cyc[b+1] - got_cyc[b] : -1, 10 * CPB);
        end
        checks++; if (ferr_cnt != f) begin errors++; $display("FAIL b2b_ferr got %0d expected 0", ferr_cnt - f); end
    endtask

    task automatic test_reset_mid();
        int b, t0;
        logic [9:0] bits;
        b = got_q.size();
        bits = {1'b1, 8'hFF, 1'b0};
        // Start bit plus data bits 0..3, then halfway into data bit 4
        for (int i = 0; i < 5; i++) begin
            rx_serial = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_serial = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b expected 1", rx_busy); end
        nRst = 1'b0;
        #2;
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_byte got %h expected 00", rx_byte); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", rx_busy); end
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
        idle(3 * CPB);
        checks++; if (got_q.size() != b) begin errors++; $display("FAIL midrst_pulses got %0d expected 0", got_q.size() - b); end
        send_frame(8'h0F, 1'b1, t0);
        idle(4);
        checks++;
        if (got_q.size() != b + 1 || rx_byte !== 8'h0F) begin
            errors++; $display("FAIL midrst_next got %h (%0d pulses) expected 0f", rx_byte, got_q.size() - b);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        int b, f, t0;
        b = got_q.size(); f = ferr_cnt;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(d, 1'b1, t0);
        end
        idle(10);
        checks++; if (got_q.size() - b != 256) begin errors++; $display("FAIL loop_count got %0d expected 256", got_q.size() - b); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (got_q.size() <= b + i || got_q[b+i] !== exp_q[i]) begin
                errors++; $display("FAIL loop_byte[%0d] got %h expected %h", i, (got_q.size() > b + i) ? got_q[b+i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (ferr_cnt != f) begin errors++; $display("FAIL loop_ferr got %0d expected 0", ferr_cnt - f); end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL ready_and_ferr_overlap got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
